// File: rtl/washing_machine_ctrl.sv
// Coin-operated washing-machine sequencer: FILL, (WASH, RINSE) x N, SPIN,
// with pause, abort-to-drain and a shared one-second prescaler.
module washing_machine_ctrl #(
  parameter int unsigned CLK_BASE_HZ    = 1_000_000,
  parameter int unsigned FILL_SEC       = 120,
  parameter int unsigned WASH_SEC       = 300,
  parameter int unsigned RINSE_SEC      = 120,
  parameter int unsigned SPIN_SEC       = 60,
  parameter int unsigned MAX_PASSES     = 3,
  parameter int unsigned COINS_REQUIRED = 1,
  parameter int unsigned SEC_W          = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       clk_freq,
  input  logic             coin_in,
  input  logic [1:0]       wash_passes,
  input  logic             pause,
  input  logic             abort,
  output logic [2:0]       phase,
  output logic [1:0]       pass_index,
  output logic [SEC_W-1:0] secs_remaining,
  output logic             busy,
  output logic             door_lock,
  output logic             wash_done,
  output logic             wash_aborted
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    FILL  = 3'b001,
    WASH  = 3'b011,
    RINSE = 3'b010,
    SPIN  = 3'b110,
    DRAIN = 3'b111
  } state_e;

  localparam logic [SEC_W-1:0] FILL_S  = SEC_W'(FILL_SEC);
  localparam logic [SEC_W-1:0] WASH_S  = SEC_W'(WASH_SEC);
  localparam logic [SEC_W-1:0] RINSE_S = SEC_W'(RINSE_SEC);
  localparam logic [SEC_W-1:0] SPIN_S  = SEC_W'(SPIN_SEC);
  localparam logic [SEC_W-1:0] ONE_S   = SEC_W'(1);
  localparam logic [3:0]       COINS   = 4'(COINS_REQUIRED);
  localparam logic [1:0]       MAXP    = 2'(MAX_PASSES);

  state_e           state_q, state_d;
  logic [3:0]       credit_q, credit_d;
  logic             coin_q, coin_d;
  logic [31:0]      pre_q, pre_d;
  logic [SEC_W-1:0] secs_q, secs_d;
  logic [1:0]       pidx_q, pidx_d;
  logic [1:0]       passes_q, passes_d;
  logic [1:0]       freq_q, freq_d;
  logic             done_q, done_d;
  logic             abrt_q, abrt_d;

  logic        coin_rise;
  logic        tick;
  logic        last_sec;
  logic        running;
  logic [31:0] pre_last;
  logic [2:0]  pidx_inc;
  logic [1:0]  p_clamp;

  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    coin_d    = coin_in;
    pre_d     = pre_q;
    secs_d    = secs_q;
    pidx_d    = pidx_q;
    passes_d  = passes_q;
    freq_d    = freq_q;
    done_d    = 1'b0;
    abrt_d    = 1'b0;
    coin_rise = coin_in & ~coin_q;
    pre_last  = (32'(CLK_BASE_HZ) << freq_q) - 32'd1;
    tick      = (pre_q == pre_last);
    last_sec  = tick && (secs_q == ONE_S);
    running   = (state_q != IDLE) && (state_q != DRAIN);
    pidx_inc  = {1'b0, pidx_q} + 3'd1;

    if (wash_passes == 2'd0) begin
      p_clamp = 2'd1;
    end else if (wash_passes > MAXP) begin
      p_clamp = MAXP;
    end else begin
      p_clamp = wash_passes;
    end

    if (state_q == IDLE) begin
      if (coin_rise) begin
        if (credit_q + 4'd1 == COINS) begin
          state_d  = FILL;
          credit_d = '0;
          passes_d = p_clamp;
          freq_d   = clk_freq;
          pre_d    = '0;
          secs_d   = FILL_S;
        end else begin
          credit_d = credit_q + 4'd1;
        end
      end
    end else if (running && abort) begin
      state_d = DRAIN;
      pre_d   = '0;
      secs_d  = SPIN_S;
      pidx_d  = '0;
    end else if (!(running && pause)) begin
      // DRAIN lands here regardless of pause so it always finishes
      pre_d = tick ? '0 : pre_q + 32'd1;
      if (tick) begin
        secs_d = secs_q - ONE_S;
      end
      if (last_sec) begin
        case (state_q)
          FILL: begin
            state_d = WASH;
            secs_d  = WASH_S;
          end
          WASH: begin
            state_d = RINSE;
            secs_d  = RINSE_S;
          end
          RINSE: begin
            if (pidx_inc < {1'b0, passes_q}) begin
              state_d = WASH;
              secs_d  = WASH_S;
              pidx_d  = pidx_inc[1:0];
            end else begin
              state_d = SPIN;
              secs_d  = SPIN_S;
            end
          end
          SPIN: begin
            state_d = IDLE;
            done_d  = 1'b1;
            pidx_d  = '0;
          end
          DRAIN: begin
            state_d = IDLE;
            abrt_d  = 1'b1;
            pidx_d  = '0;
          end
          default: begin
            state_d = IDLE;
            pidx_d  = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      coin_q   <= 1'b0;
      pre_q    <= '0;
      secs_q   <= '0;
      pidx_q   <= '0;
      passes_q <= 2'd1;
      freq_q   <= '0;
      done_q   <= 1'b0;
      abrt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      coin_q   <= coin_d;
      pre_q    <= pre_d;
      secs_q   <= secs_d;
      pidx_q   <= pidx_d;
      passes_q <= passes_d;
      freq_q   <= freq_d;
      done_q   <= done_d;
      abrt_q   <= abrt_d;
    end
  end

  assign phase          = state_q;
  assign pass_index     = pidx_q;
  assign secs_remaining = secs_q;
  assign busy           = (state_q != IDLE);
  assign door_lock      = (state_q != IDLE);
  assign wash_done      = done_q;
  assign wash_aborted   = abrt_q;

endmodule

// File: tb/tb_washing_machine_ctrl.sv
// Scoreboard bench: each phase change is popped from an expected-event
// queue and checked for code, cycle offset, pass index, seconds and pulses.
module tb_washing_machine_ctrl;

  localparam int SEC_W = 9;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       clk_freq = '0;
  logic             coin_in = 1'b0;
  logic [1:0]       wash_passes = 2'd1;
  logic             pause = 1'b0;
  logic             abort = 1'b0;
  logic [2:0]       phase;
  logic [1:0]       pass_index;
  logic [SEC_W-1:0] secs_remaining;
  logic             busy;
  logic             door_lock;
  logic             wash_done;
  logic             wash_aborted;

  washing_machine_ctrl #(
    .CLK_BASE_HZ(4),
    .FILL_SEC(2),
    .WASH_SEC(3),
    .RINSE_SEC(2),
    .SPIN_SEC(1),
    .MAX_PASSES(3),
    .COINS_REQUIRED(2),
    .SEC_W(SEC_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clk_freq(clk_freq),
    .coin_in(coin_in),
    .wash_passes(wash_passes),
    .pause(pause),
    .abort(abort),
    .phase(phase),
    .pass_index(pass_index),
    .secs_remaining(secs_remaining),
    .busy(busy),
    .door_lock(door_lock),
    .wash_done(wash_done),
    .wash_aborted(wash_aborted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       ph;
    int               at;
    logic [1:0]       pidx;
    logic [SEC_W-1:0] secs;
    logic             done;
    logic             abt;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   compares = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0 = 0;
  logic [2:0] prev_ph = 3'b000;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      prev_ph = 3'b000;
    end else if (phase !== prev_ph) begin
      compares++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: phase=%b at t=%0d, none required",
                 phase, cyc - t0);
      end else begin
        e = sbq.pop_front();
        if (phase !== e.ph || (cyc - t0) != e.at || pass_index !== e.pidx ||
            secs_remaining !== e.secs || wash_done !== e.done ||
            wash_aborted !== e.abt) begin
          errors++;
          $display("FAIL sb_event: got ph=%b t=%0d pi=%0d s=%0d d=%b a=%b, req ph=%b t=%0d pi=%0d s=%0d d=%b a=%b",
                   phase, cyc - t0, pass_index, secs_remaining, wash_done,
                   wash_aborted, e.ph, e.at, e.pidx, e.secs, e.done, e.abt);
        end
      end
      prev_ph = phase;
    end else if (wash_done || wash_aborted) begin
      compares++;
      errors++;
      $display("FAIL sb_stray_pulse: done=%b aborted=%b, required 0 0",
               wash_done, wash_aborted);
    end
  end

  function automatic void push(input logic [2:0] ph, input int at,
                               input logic [1:0] pi, input int s,
                               input logic d, input logic a);
    exp_t x;
    x.ph = ph; x.at = at; x.pidx = pi;
    x.secs = SEC_W'(s); x.done = d; x.abt = a;
    sbq.push_back(x);
  endfunction

  // d = extra cycles added inside the first WASH pass
  function automatic void plan_program(input int p, input int n, input int d);
    int t = 0;
    push(3'b001, t, 2'd0, 2, 1'b0, 1'b0);
    t += 2 * n;
    for (int i = 0; i < p; i++) begin
      push(3'b011, t, 2'(i), 3, 1'b0, 1'b0);
      t += 3 * n + ((i == 0) ? d : 0);
      push(3'b010, t, 2'(i), 2, 1'b0, 1'b0);
      t += 2 * n;
    end
    push(3'b110, t, 2'(p - 1), 1, 1'b0, 1'b0);
    t += n;
    push(3'b000, t, 2'd0, 0, 1'b1, 1'b0);
  endfunction

  task automatic coin_pulse();
    @(negedge clk);
    coin_in = 1'b1;
    @(negedge clk);
    coin_in = 1'b0;
  endtask

  task automatic start_program(input int p, input int f, input int coins);
    wash_passes = 2'(p);
    clk_freq = 2'(f);
    for (int i = 0; i < coins; i++) begin
      @(negedge clk);
      coin_in = 1'b1;
      if (i == coins - 1) t0 = cyc + 1;
      @(negedge clk);
      coin_in = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    compares++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d events pending after %0d cycles, required 0",
               sbq.size(), budget);
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    compares += 7;
    if (phase !== 3'b000) begin errors++; $display("FAIL rst_phase: %b req 000", phase); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: %b req 0", busy); end
    if (door_lock !== 1'b0) begin errors++; $display("FAIL rst_lock: %b req 0", door_lock); end
    if (secs_remaining !== '0) begin errors++; $display("FAIL rst_secs: %0d req 0", secs_remaining); end
    if (pass_index !== 2'd0) begin errors++; $display("FAIL rst_pidx: %0d req 0", pass_index); end
    if (wash_done !== 1'b0) begin errors++; $display("FAIL rst_done: %b req 0", wash_done); end
    if (wash_aborted !== 1'b0) begin errors++; $display("FAIL rst_abt: %b req 0", wash_aborted); end
    rst = 1'b0;
  endtask

  task automatic test_credit();
    coin_pulse();
    repeat (100) @(negedge clk);
    compares += 2;
    if (phase !== 3'b000) begin errors++; $display("FAIL one_coin_phase: %b req 000", phase); end
    if (busy !== 1'b0) begin errors++; $display("FAIL one_coin_busy: %b req 0", busy); end
    plan_program(1, 4, 0);
    start_program(1, 0, 1);
    repeat (3) @(negedge clk);
    compares += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL run_busy: %b req 1", busy); end
    if (door_lock !== 1'b1) begin errors++; $display("FAIL run_lock: %b req 1", door_lock); end
    coin_pulse();
    wait_done(100);
    coin_pulse();
    repeat (20) @(negedge clk);
    compares++;
    if (phase !== 3'b000) begin errors++; $display("FAIL credit_cleared: %b req 000", phase); end
  endtask

  task automatic test_passes();
    plan_program(1, 4, 0);
    start_program(0, 0, 1);
    wait_done(100);
    plan_program(2, 4, 0);
    start_program(2, 0, 2);
    wait_done(150);
    plan_program(3, 4, 0);
    start_program(3, 0, 2);
    wait_done(200);
  endtask

  task automatic test_freq();
    plan_program(1, 8, 0);
    start_program(1, 1, 2);
    repeat (4) @(negedge clk);
    clk_freq = 2'd3;
    wait_done(200);
    clk_freq = 2'd0;
  endtask

  task automatic test_pause();
    logic [SEC_W-1:0] s0;
    int bad = 0;
    plan_program(1, 4, 10);
    start_program(1, 0, 2);
    repeat (11) @(negedge clk);
    s0 = secs_remaining;
    pause = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (secs_remaining !== s0 || phase !== 3'b011) bad++;
    end
    pause = 1'b0;
    compares++;
    if (bad != 0) begin
      errors++;
      $display("FAIL pause_freeze: %0d cycles moved (secs=%0d ph=%b), req 0",
               bad, secs_remaining, phase);
    end
    wait_done(100);
  endtask

  task automatic test_abort();
    push(3'b001, 0, 2'd0, 2, 1'b0, 1'b0);
    push(3'b011, 8, 2'd0, 3, 1'b0, 1'b0);
    push(3'b111, 20, 2'd0, 1, 1'b0, 1'b0);
    push(3'b000, 24, 2'd0, 0, 1'b0, 1'b1);
    start_program(1, 0, 2);
    repeat (19) @(negedge clk);
    abort = 1'b1;
    pause = 1'b1;
    @(negedge clk);
    compares += 2;
    if (phase !== 3'b111) begin errors++; $display("FAIL abort_phase: %b req 111", phase); end
    if (secs_remaining !== SEC_W'(1)) begin errors++; $display("FAIL abort_secs: %0d req 1", secs_remaining); end
    repeat (2) @(negedge clk);
    abort = 1'b0;
    wait_done(50);
    pause = 1'b0;
  endtask

  task automatic test_reset_mid();
    plan_program(1, 4, 0);
    start_program(1, 0, 2);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    #1;
    compares += 7;
    if (phase !== 3'b000) begin errors++; $display("FAIL mid_rst_phase: %b req 000", phase); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: %b req 0", busy); end
    if (door_lock !== 1'b0) begin errors++; $display("FAIL mid_rst_lock: %b req 0", door_lock); end
    if (secs_remaining !== '0) begin errors++; $display("FAIL mid_rst_secs: %0d req 0", secs_remaining); end
    if (pass_index !== 2'd0) begin errors++; $display("FAIL mid_rst_pidx: %0d req 0", pass_index); end
    if (wash_done !== 1'b0) begin errors++; $display("FAIL mid_rst_done: %b req 0", wash_done); end
    if (wash_aborted !== 1'b0) begin errors++; $display("FAIL mid_rst_abt: %b req 0", wash_aborted); end
    sbq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_credit();
    test_passes();
    test_freq();
    test_pause();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
